// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of the PC sequencer: branch-resolution inputs in, fetch address and status out.
// master = execute/hazard side driving the resolve fields; slave = the sequencer.
interface pc_sequencer_if;
    logic        stall;
    logic        resolve_valid;
    logic [1:0]  pc_src;
    logic [31:0] resolve_pc;
    logic [25:0] jump_target;
    logic [15:0] branch_offset;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush;
    logic        align_err;
    logic [31:0] redirect_count;

    modport master (
        output stall, resolve_valid, pc_src, resolve_pc, jump_target, branch_offset, jr_target,
        input  pc, pc_plus4, fetch_valid, flush, align_err, redirect_count
    );

    modport slave (
        input  stall, resolve_valid, pc_src, resolve_pc, jump_target, branch_offset, jr_target,
        output pc, pc_plus4, fetch_valid, flush, align_err, redirect_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC register and next-fetch sequencing with post-redirect flush bubbles.
// Optional macro PC_REDIRECT_CNT_EN builds the saturating accepted-redirect counter.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    pc_sequencer_if.slave     bus
);
    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic        align_reg, align_next;

    logic        redirect;
    logic [31:0] resolve_pc_plus4;
    logic [31:0] branch_disp;
    logic [31:0] target;

    assign resolve_pc_plus4 = bus.resolve_pc + 32'd4;
    assign branch_disp      = {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    assign redirect         = (state_reg == RUN) && bus.resolve_valid && (bus.pc_src != 2'b11);

    always_comb begin
        target = resolve_pc_plus4;
        case (bus.pc_src)
            2'b00:   target = {bus.jr_target[31:2], 2'b00};
            2'b01:   target = {resolve_pc_plus4[31:28], bus.jump_target, 2'b00};
            2'b10:   target = resolve_pc_plus4 + branch_disp;
            default: target = resolve_pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_PC;
            cnt_reg   <= 2'd0;
            align_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
            align_reg <= align_next;
        end
    end

    // A redirect wins over stall; FLUSH ignores both stall and resolve inputs.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        align_next = align_reg;
        case (state_reg)
            BOOT: state_next = RUN;
            RUN: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = FLUSH;
                    cnt_next   = FLUSH_INIT;
                    if (bus.pc_src == 2'b00 && bus.jr_target[1:0] != 2'b00)
                        align_next = 1'b1;
                end else if (!bus.stall) begin
                    pc_next = pc_reg + 32'd4;
                end
            end
            FLUSH: begin
                if (cnt_reg != 2'd0)
                    cnt_next = cnt_reg - 2'd1;
                else
                    state_next = RUN;
            end
            default: state_next = BOOT;
        endcase
    end

`ifdef PC_REDIRECT_CNT_EN
    logic [31:0] redirect_count_reg;

    always_ff @(posedge clk) begin
        if (reset)
            redirect_count_reg <= 32'd0;
        else if (redirect && redirect_count_reg != 32'hFFFF_FFFF)
            redirect_count_reg <= redirect_count_reg + 32'd1;
    end

    assign bus.redirect_count = redirect_count_reg;
`else
    assign bus.redirect_count = 32'd0;
`endif

    assign bus.pc          = pc_reg;
    assign bus.pc_plus4    = pc_reg + 32'd4;
    assign bus.fetch_valid = (state_reg == RUN);
    assign bus.flush       = (state_reg == FLUSH);
    assign bus.align_err   = align_reg;
endmodule

// File: tb/tb_pc_sequencer.sv
// Three pc_sequencer configurations driven by shared stimulus, each checked every cycle
// against a bubble-counting reference model, plus directed constant checks.
module tb_pc_sequencer;
    logic        clk;
    logic        reset;
    logic        stall;
    logic        resolve_valid;
    logic [1:0]  pc_src;
    logic [31:0] resolve_pc;
    logic [25:0] jump_target;
    logic [15:0] branch_offset;
    logic [31:0] jr_target;

    int total = 0;
    int bad   = 0;

    pc_sequencer_if bus0 ();
    pc_sequencer_if bus1 ();
    pc_sequencer_if bus2 ();

    assign bus0.stall = stall;          assign bus1.stall = stall;          assign bus2.stall = stall;
    assign bus0.resolve_valid = resolve_valid;
    assign bus1.resolve_valid = resolve_valid;
    assign bus2.resolve_valid = resolve_valid;
    assign bus0.pc_src = pc_src;        assign bus1.pc_src = pc_src;        assign bus2.pc_src = pc_src;
    assign bus0.resolve_pc = resolve_pc;
    assign bus1.resolve_pc = resolve_pc;
    assign bus2.resolve_pc = resolve_pc;
    assign bus0.jump_target = jump_target;
    assign bus1.jump_target = jump_target;
    assign bus2.jump_target = jump_target;
    assign bus0.branch_offset = branch_offset;
    assign bus1.branch_offset = branch_offset;
    assign bus2.branch_offset = branch_offset;
    assign bus0.jr_target = jr_target;  assign bus1.jr_target = jr_target;  assign bus2.jr_target = jr_target;

    pc_sequencer #(.RESET_PC(32'h0040_0000), .FLUSH_CYCLES(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    pc_sequencer #(.RESET_PC(32'h0040_0000), .FLUSH_CYCLES(3)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .FLUSH_CYCLES(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    logic [31:0] o_pc [3];
    logic [31:0] o_p4 [3];
    logic [31:0] o_rc [3];
    logic        o_fv [3];
    logic        o_fl [3];
    logic        o_ae [3];

    assign o_pc[0] = bus0.pc;  assign o_pc[1] = bus1.pc;  assign o_pc[2] = bus2.pc;
    assign o_p4[0] = bus0.pc_plus4;  assign o_p4[1] = bus1.pc_plus4;  assign o_p4[2] = bus2.pc_plus4;
    assign o_rc[0] = bus0.redirect_count;
    assign o_rc[1] = bus1.redirect_count;
    assign o_rc[2] = bus2.redirect_count;
    assign o_fv[0] = bus0.fetch_valid;  assign o_fv[1] = bus1.fetch_valid;  assign o_fv[2] = bus2.fetch_valid;
    assign o_fl[0] = bus0.flush;  assign o_fl[1] = bus1.flush;  assign o_fl[2] = bus2.flush;
    assign o_ae[0] = bus0.align_err;  assign o_ae[1] = bus1.align_err;  assign o_ae[2] = bus2.align_err;

    // Reference model: a boot flag plus a count of bubble cycles still owed.
    logic [31:0] p_rpc [3] = '{32'h0040_0000, 32'h0040_0000, 32'hFFFF_FFFC};
    int          p_fc  [3] = '{1, 3, 2};
    logic [31:0] m_pc  [3];
    logic        m_boot[3];
    int          m_bub [3];
    logic        m_ae  [3];
    logic [31:0] m_cnt [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] redirect_target();
        logic [31:0] rp4;
        int          so;
        rp4 = resolve_pc + 32'd4;
        so  = int'($signed(branch_offset));
        case (pc_src)
            2'b00:   return jr_target & ~32'd3;
            2'b01:   return (rp4 & 32'hF000_0000) | ({6'd0, jump_target} * 32'd4);
            default: return rp4 + 32'(so * 4);
        endcase
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_pc[i] = p_rpc[i]; m_boot[i] = 1'b1; m_bub[i] = 0; m_ae[i] = 1'b0; m_cnt[i] = 32'd0;
            end else if (m_boot[i]) begin
                m_boot[i] = 1'b0;
            end else if (m_bub[i] > 0) begin
                m_bub[i] = m_bub[i] - 1;
            end else if (resolve_valid && pc_src != 2'b11) begin
                m_pc[i] = redirect_target();
                if (pc_src == 2'b00 && jr_target[1:0] != 2'b00) m_ae[i] = 1'b1;
                m_bub[i] = p_fc[i];
                if (m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 32'd1;
            end else if (!stall) begin
                m_pc[i] = m_pc[i] + 32'd4;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_rc;
        for (int i = 0; i < 3; i++) begin
`ifdef PC_REDIRECT_CNT_EN
            exp_rc = m_cnt[i];
`else
            exp_rc = 32'd0;
`endif
            chk($sformatf("d%0d.pc", i), o_pc[i], m_pc[i]);
            chk($sformatf("d%0d.pc_plus4", i), o_p4[i], m_pc[i] + 32'd4);
            chk($sformatf("d%0d.fetch_valid", i), {31'd0, o_fv[i]}, {31'd0, (!m_boot[i] && m_bub[i] == 0)});
            chk($sformatf("d%0d.flush", i), {31'd0, o_fl[i]}, {31'd0, (m_bub[i] > 0)});
            chk($sformatf("d%0d.align_err", i), {31'd0, o_ae[i]}, {31'd0, m_ae[i]});
            chk($sformatf("d%0d.redirect_count", i), o_rc[i], exp_rc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int          nf;
        logic [31:0] held;

        reset = 1'b1; stall = 1'b0; resolve_valid = 1'b0; pc_src = 2'b11;
        resolve_pc = 32'd0; jump_target = 26'd0; branch_offset = 16'd0; jr_target = 32'd0;

        // Reset two cycles; the last one is observed as BOOT.
        tick(); tick();
        chk("boot.pc", o_pc[0], 32'h0040_0000);
        chk("boot.fetch_valid", {31'd0, o_fv[0]}, 32'd0);
        reset = 1'b0;
        tick();
        chk("run0.pc", o_pc[0], 32'h0040_0000);
        chk("wrap.first_pc", o_pc[2], 32'hFFFF_FFFC);
        chk("wrap.pc_plus4", o_p4[2], 32'h0000_0000);
        tick();
        chk("run1.pc", o_pc[0], 32'h0040_0004);
        chk("wrap.second_pc", o_pc[2], 32'h0000_0000);
        tick();
        chk("run2.pc", o_pc[0], 32'h0040_0008);

        // J/JAL redirect
        resolve_valid = 1'b1; pc_src = 2'b01; resolve_pc = 32'h0040_0008; jump_target = 26'h0100010;
        tick();
        resolve_valid = 1'b0;
        chk("j.flush", {31'd0, o_fl[0]}, 32'd1);
        tick();
        chk("j.pc", o_pc[0], 32'h0040_0040);
        chk("j.fetch_valid", {31'd0, o_fv[0]}, 32'd1);
        tick(); tick();

        // Branch taken backwards; FLUSH_CYCLES=3 instance must show exactly 3 bubbles.
        resolve_valid = 1'b1; pc_src = 2'b10; resolve_pc = 32'h0040_0010; branch_offset = 16'hFFFC;
        nf = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            resolve_valid = 1'b0;
            if (o_fl[1]) nf++;
            if (k == 1) chk("br.pc", o_pc[0], 32'h0040_0004);
        end
        chk("br.flush_len3", nf, 32'd3);

        // JR with misaligned target
        resolve_valid = 1'b1; pc_src = 2'b00; jr_target = 32'h0040_0103;
        tick();
        resolve_valid = 1'b0;
        tick();
        chk("jr.pc", o_pc[0], 32'h0040_0100);
        chk("jr.align_err", {31'd0, o_ae[0]}, 32'd1);
        for (int k = 0; k < 10; k++) tick();
        chk("jr.align_hold", {31'd0, o_ae[0]}, 32'd1);

        // Stall holds pc
        stall = 1'b1;
        held = o_pc[0];
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall.hold", o_pc[0], held);
        end

        // Redirect beats stall
        resolve_valid = 1'b1; pc_src = 2'b10; resolve_pc = 32'h0040_0200; branch_offset = 16'h0010;
        tick();
        resolve_valid = 1'b0; stall = 1'b0;
        tick();
        chk("stall_br.pc", o_pc[0], 32'h0040_0244);
        tick(); tick(); tick();

        // resolve_valid during FLUSH is ignored
        resolve_valid = 1'b1; pc_src = 2'b01; resolve_pc = 32'h0040_0244; jump_target = 26'h0100080;
        tick();
        jump_target = 26'h0100100;
        tick();
        resolve_valid = 1'b0;
        chk("flush_ign.pc", o_pc[0], 32'h0040_0200);
        tick(); tick(); tick();

        // Reset mid-flush
        resolve_valid = 1'b1; pc_src = 2'b01; resolve_pc = 32'h0040_0200; jump_target = 26'h0100100;
        tick();
        resolve_valid = 1'b0;
        chk("rst_flush.in_flush", {31'd0, o_fl[0]}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rst_flush.pc", o_pc[0], 32'h0040_0000);
        chk("rst_flush.flush", {31'd0, o_fl[0]}, 32'd0);
        chk("rst_flush.align_err", {31'd0, o_ae[0]}, 32'd0);
        chk("rst_flush.pc_wrapcfg", o_pc[2], 32'hFFFF_FFFC);
        reset = 1'b0;
        tick();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            reset         = ($urandom_range(0, 39) == 0);
            stall         = ($urandom_range(0, 9) < 3);
            resolve_valid = $urandom_range(0, 1) == 1;
            pc_src        = 2'($urandom_range(0, 3));
            resolve_pc    = $urandom;
            jump_target   = 26'($urandom);
            branch_offset = 16'($urandom);
            jr_target     = $urandom;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
